// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid bit, stall/bubble/flush handling
// and saturating per-stage stall, bubble and flush counters.
module pipe_stage_reg #(
   parameter int unsigned DW        = 160,
   parameter int unsigned CW        = 16,
   parameter int unsigned NSTAGE    = 5,
   parameter int unsigned STAGE     = 2,
   parameter logic [DW-1:0] KEEP_MASK = '0,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NSTAGE-1:0] stall,
   input  logic [NSTAGE-1:0] flush,
   input  logic              valid_in,
   input  logic [CW-1:0]     ctrl_in,
   input  logic [DW-1:0]     data_in,
   input  logic              cnt_clr,
   output logic              valid_out,
   output logic [CW-1:0]     ctrl_out,
   output logic [DW-1:0]     data_out,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   if (STAGE < 1 || STAGE >= NSTAGE) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE must be in 1..NSTAGE-1");
   end

   logic             hold, bubble, flush_hit;
   logic             valid_d, valid_q;
   logic [CW-1:0]    ctrl_d, ctrl_q;
   logic [DW-1:0]    data_d, data_q;
   logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

   // Only two stall bits and one flush bit matter to this boundary.
   logic unused_vec;
   assign unused_vec = ^{stall, flush};

   assign hold      = stall[STAGE];
   assign bubble    = ~stall[STAGE] & stall[STAGE-1];
   assign flush_hit = flush[STAGE-1];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      valid_d = valid_in;
      ctrl_d  = ctrl_in;
      data_d  = data_in;
      if (hold) begin
         valid_d = valid_q;
         ctrl_d  = ctrl_q;
         data_d  = data_q;
      end else if (bubble) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         data_d  = '0;
      end
      // Flush masks the action-selected data so kept bits still hold/load.
      if (flush_hit) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         data_d  = data_d & KEEP_MASK;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || cnt_clr) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         if (hold && !flush_hit)   stall_cnt_q  <= sat_inc(stall_cnt_q);
         if (bubble && !flush_hit) bubble_cnt_q <= sat_inc(bubble_cnt_q);
         if (flush_hit)            flush_cnt_q  <= sat_inc(flush_cnt_q);
      end
   end

   assign valid_out  = valid_q;
   assign ctrl_out   = ctrl_q;
   assign data_out   = data_q;
   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
   assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one instance with no kept bits and a
// 3-bit counter, one with the low data byte kept across flush.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  stall, flush;
   logic        valid_in, cnt_clr;
   logic [7:0]  ctrl_in;
   logic [15:0] data_in;

   logic        a_valid, k_valid;
   logic [7:0]  a_ctrl, k_ctrl;
   logic [15:0] a_data, k_data;
   logic [2:0]  a_scnt, a_bcnt, a_fcnt;
   logic [15:0] k_scnt, k_bcnt, k_fcnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DW(16), .CW(8), .NSTAGE(5), .STAGE(2), .KEEP_MASK(16'h0000), .CNT_W(3)
   ) dut_a (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in), .cnt_clr(cnt_clr),
      .valid_out(a_valid), .ctrl_out(a_ctrl), .data_out(a_data),
      .stall_cnt(a_scnt), .bubble_cnt(a_bcnt), .flush_cnt(a_fcnt)
   );

   pipe_stage_reg #(
      .DW(16), .CW(8), .NSTAGE(5), .STAGE(2), .KEEP_MASK(16'h00FF), .CNT_W(16)
   ) dut_k (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in), .cnt_clr(cnt_clr),
      .valid_out(k_valid), .ctrl_out(k_ctrl), .data_out(k_data),
      .stall_cnt(k_scnt), .bubble_cnt(k_bcnt), .flush_cnt(k_fcnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = '0; flush = '0; cnt_clr = 1'b0;
      valid_in = 1'b1; ctrl_in = 8'h03; data_in = 16'h00AB;
      tick();
      tick();
      check("rst_valid", 32'(a_valid), 32'd0);
      check("rst_ctrl", 32'(a_ctrl), 32'd0);
      check("rst_data", 32'(a_data), 32'd0);
      check("rst_scnt", 32'(a_scnt), 32'd0);
      check("rst_fcnt_k", 32'(k_fcnt), 32'd0);

      reset = 1'b0;
      tick();
      check("load_data", 32'(a_data), 32'h00AB);
      check("load_ctrl", 32'(a_ctrl), 32'h3);
      check("load_valid", 32'(a_valid), 32'd1);

      // Hold vs bubble
      data_in = 16'h0011;
      tick();
      stall = 5'b00100; data_in = 16'h0022;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_data", 32'(a_data), 32'h0011);
      end
      check("hold_scnt", 32'(a_scnt), 32'd3);
      check("hold_valid", 32'(a_valid), 32'd1);
      stall = 5'b00010;
      tick();
      check("bub_valid", 32'(a_valid), 32'd0);
      check("bub_ctrl", 32'(a_ctrl), 32'd0);
      check("bub_data", 32'(a_data), 32'd0);
      check("bub_bcnt", 32'(a_bcnt), 32'd1);
      check("bub_scnt", 32'(a_scnt), 32'd3);

      // Flush with kept low byte
      stall = '0; flush = 5'b00010; data_in = 16'hABCD; ctrl_in = 8'h0F;
      tick();
      check("fk_data", 32'(k_data), 32'h00CD);
      check("fk_ctrl", 32'(k_ctrl), 32'd0);
      check("fk_valid", 32'(k_valid), 32'd0);
      check("fk_fcnt", 32'(k_fcnt), 32'd1);
      check("fa_data", 32'(a_data), 32'd0);

      // flush[STAGE] is ignored
      flush = 5'b00100; data_in = 16'h5A5A;
      tick();
      check("fign_data", 32'(k_data), 32'h5A5A);
      check("fign_valid", 32'(k_valid), 32'd1);
      check("fign_fcnt", 32'(k_fcnt), 32'd1);

      // Flush during hold
      flush = '0; data_in = 16'h1234;
      tick();
      stall = 5'b00100; data_in = 16'h9999;
      tick();
      check("fh_pre_scnt", 32'(a_scnt), 32'd4);
      flush = 5'b00010;
      tick();
      check("fh_data", 32'(a_data), 32'd0);
      check("fh_valid", 32'(a_valid), 32'd0);
      check("fh_scnt", 32'(a_scnt), 32'd4);
      check("fh_fcnt", 32'(a_fcnt), 32'd2);
      check("fh_kdata", 32'(k_data), 32'h0034);

      // Saturation and clear
      flush = '0;
      for (int i = 0; i < 10; i++) tick();
      check("sat_scnt", 32'(a_scnt), 32'd7);
      check("sat_kscnt", 32'(k_scnt), 32'd14);
      cnt_clr = 1'b1;
      tick();
      check("clr_scnt", 32'(a_scnt), 32'd0);
      check("clr_kfcnt", 32'(k_fcnt), 32'd0);
      check("clr_kdata", 32'(k_data), 32'h0034);
      cnt_clr = 1'b0;

      // Reset mid-stall
      stall = '0; data_in = 16'h0055;
      tick();
      stall = 5'b00100; data_in = 16'h0077;
      tick();
      check("ms_held", 32'(a_data), 32'h0055);
      reset = 1'b1;
      tick();
      check("ms_rst_data", 32'(a_data), 32'd0);
      check("ms_rst_kdata", 32'(k_data), 32'd0);
      check("ms_rst_scnt", 32'(k_scnt), 32'd0);
      reset = 1'b0; stall = '0; data_in = 16'h0066;
      tick();
      check("ms_load", 32'(a_data), 32'h0066);

      // Bubble and flush together
      stall = 5'b00010; flush = 5'b00010;
      tick();
      check("bf_valid", 32'(k_valid), 32'd0);
      check("bf_kdata", 32'(k_data), 32'd0);
      check("bf_bcnt", 32'(k_bcnt), 32'd0);
      check("bf_fcnt", 32'(k_fcnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS pipeline. It replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that is instantiated per boundary. The block carries a packed control vector and a packed data vector, adds an explicit valid bit, applies stall, bubble and flush with fixed priority, and keeps saturating per-stage stall, bubble and flush counters for performance debug.

## Interface
Parameters:
- DW, 160: width of the packed data payload (PC+4, operands, extended immediate, store data, register numbers).
- CW, 16: width of the packed control vector (MemWrite, MemRead, RegWrite, MemtoReg, ALUCtrl, ALUsrc, branch, RegDst, sign, …).
- NSTAGE, 5: width of the global stall/flush vectors.
- STAGE, 2: index of this register's downstream stage. Legal range is 1..NSTAGE-1; an out-of-range value is an elaboration error.
- KEEP_MASK, {DW{1'b0}}: data bits set to 1 survive a flush. For example, the PC+4 field is kept for exception/EPC use.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  NSTAGE  global stall vector from the hazard unit.
- flush  in  NSTAGE  global flush vector from branch/jump/exception logic.
- valid_in  in  1  upstream stage holds a real instruction.
- ctrl_in  in  CW  upstream control vector.
- data_in  in  DW  upstream data payload.
- cnt_clr  in  1  synchronous clear of all three counters.
- valid_out  out  1  registered valid.
- ctrl_out  out  CW  registered control.
- data_out  out  DW  registered data.
- stall_cnt  out  CNT_W  cycles spent in HOLD.
- bubble_cnt  out  CNT_W  bubbles inserted.
- flush_cnt  out  CNT_W  flushes applied.

## Operation
Each cycle the block computes an action from `stall[STAGE]` and `stall[STAGE-1]`:
- HOLD: `stall[STAGE]` = 1. All outputs keep their current values.
- BUBBLE: `stall[STAGE]` = 0 and `stall[STAGE-1]` = 1. `valid_out`, `ctrl_out` and `data_out` all load 0.
- LOAD: neither stall bit set. Outputs load `valid_in`, `ctrl_in` and `data_in`.

Flush:
- Flush is asserted by `flush[STAGE-1]` = 1. It overrides all three actions, including HOLD.
- On flush, `valid_out` and `ctrl_out` load 0.
- On flush, `data_out` loads (action-selected next data) & KEEP_MASK. Kept bits therefore still follow HOLD, BUBBLE or LOAD.
- `flush[STAGE]` and all other vector bits are ignored.

Counters:
- `stall_cnt` increments on HOLD without flush.
- `bubble_cnt` increments on BUBBLE without flush.
- `flush_cnt` increments on any cycle with flush.
- Every counter saturates at 2^CNT_W−1 and never wraps.
- `cnt_clr` forces all counters to 0 and beats a same-cycle increment. Datapath registers are unaffected.

Reset:
- `reset` zeroes every output: valid, ctrl, data (including KEEP_MASK bits) and all counters.
- `reset` overrides stall, flush and `cnt_clr`.
- Reset asserted mid-stall fully clears the register. The first post-reset cycle with no stall performs LOAD.

Combinational rules:
- No combinational path from any input to any output.
- Outputs depend only on registered state.

## Timing
- Latency: 1 cycle, `data_in` to `data_out` on LOAD.
- HOLD sustains indefinitely; outputs are stable for every held cycle.
- Flush takes effect at the same edge it is sampled.
- A flush held for N cycles yields N cleared cycles and `flush_cnt` += N.
- Simultaneous `stall[STAGE]` and `flush[STAGE-1]`: flush wins. valid/ctrl clear, kept data bits hold, `stall_cnt` does not increment.
- Simultaneous `stall[STAGE-1]` and `flush[STAGE-1]`: result is a cleared register. Only `flush_cnt` increments.
- Counter saturation: at all-ones a further event leaves the value at all-ones.
- Counter values are visible one cycle after the counted edge.

## Test plan
- Reset/load: assert reset for 2 cycles with `stall`=`flush`=0, `data_in`=0xAB, `ctrl_in`=0x3, `valid_in`=1 → all outputs 0 during reset. On the first edge after release, `data_out`=0xAB, `ctrl_out`=0x3, `valid_out`=1.
- Hold vs bubble (STAGE=2): load 0x11, then `stall`=5'b00100 for 3 cycles with `data_in`=0x22 → `data_out` stays 0x11 and `stall_cnt`=3. Then `stall`=5'b00010 for 1 cycle → outputs all 0, `bubble_cnt`=1.
- Flush with KEEP_MASK=0xFF, DW=16: `data_in`=0xABCD, `ctrl_in`=0xF, `flush`=5'b00010 → `data_out`=0x00CD, `ctrl_out`=0, `valid_out`=0, `flush_cnt`=1.
- Flush during hold: hold 0x1234 with `stall[2]`=1, assert `flush[1]` for 1 cycle with KEEP_MASK=0 → `data_out`=0, `valid_out`=0, `stall_cnt` unchanged, `flush_cnt`+1.
- Saturation/clear with CNT_W=3: hold for 10 cycles → `stall_cnt`=7. Then `cnt_clr`=1 with `stall[2]`=1 → `stall_cnt`=0 on the next edge.
- Reset mid-stall: `stall[2]`=1 with data 0x55 held, assert reset 1 cycle → data 0. Release reset with `stall`=0 and `data_in`=0x66 → `data_out`=0x66.
